// File: rtl/bus_pkg.sv
// Shared types and constants for the bus grant sequencer.
package bus_pkg;

  localparam int DEF_NUMUNITS     = 32'd8;
  localparam int DEF_ADDRESSWIDTH = 32'd3;
  localparam int DEF_TIMEOUT      = 32'd15;

  // Ownership life cycle of the shared bus.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWNED   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 32'd0;
    span   = 32'd1;
    while (span < value) begin
      span   = span * 32'd2;
      result = result + 32'd1;
    end
    return result;
  endfunction

  // Watchdog counter width: counts 0 .. TIMEOUT-1, never narrower than one bit.
  function automatic int wd_width(input int timeout);
    int w;
    w = clog2(timeout);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/grant_select.sv
// Combinational winner selection: optional minimum-priority filter followed by
// a rotating first-one search that starts at the round-robin pointer.
module grant_select
  import bus_pkg::*;
#(
  parameter int NUMUNITS     = DEF_NUMUNITS,
  parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH
) (
  input  logic [NUMUNITS-1:0]              i_request,
  input  logic [ADDRESSWIDTH*NUMUNITS-1:0] i_priority,
  input  logic                             i_roundORpriority,
  input  logic [ADDRESSWIDTH-1:0]          i_pointer,
  output logic                             o_valid,
  output logic [ADDRESSWIDTH-1:0]          o_winner
);

  // One extra bit so pointer + offset never overflows before the wrap.
  localparam int SW = ADDRESSWIDTH + 1;

  logic [ADDRESSWIDTH-1:0] w_min_prio;
  logic [NUMUNITS-1:0]     w_cand;
  logic [SW-1:0]           w_scan;
  logic [ADDRESSWIDTH-1:0] w_idx;

  // Smallest priority value among the active requesters.
  always_comb begin
    w_min_prio = '1;
    for (int i = 0; i < NUMUNITS; i++) begin
      if (i_request[i] && (i_priority[i*ADDRESSWIDTH +: ADDRESSWIDTH] < w_min_prio)) begin
        w_min_prio = i_priority[i*ADDRESSWIDTH +: ADDRESSWIDTH];
      end else begin
        w_min_prio = w_min_prio;
      end
    end
  end

  // Candidate set: all requesters, or only the most urgent ones in priority mode.
  always_comb begin
    w_cand = '0;
    for (int i = 0; i < NUMUNITS; i++) begin
      w_cand[i] = i_request[i] &&
                  (!i_roundORpriority ||
                   (i_priority[i*ADDRESSWIDTH +: ADDRESSWIDTH] == w_min_prio));
    end
  end

  // First candidate found scanning pointer, pointer+1, ... modulo NUMUNITS.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = '0;
    w_scan   = '0;
    w_idx    = '0;
    for (int k = 0; k < NUMUNITS; k++) begin
      w_scan = {1'b0, i_pointer} + SW'(k);
      if (w_scan >= SW'(NUMUNITS)) begin
        w_scan = w_scan - SW'(NUMUNITS);
      end else begin
        w_scan = w_scan;
      end
      w_idx = w_scan[ADDRESSWIDTH-1:0];
      if (!o_valid && w_cand[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = w_idx;
      end else begin
        o_valid  = o_valid;
      end
    end
  end

endmodule

// File: rtl/bus_grant_sequencer.sv
// Burst-level bus ownership controller: round-robin or priority arbitration,
// one-hot grant held for a whole burst, abandon/watchdog reclaim and a single
// turnaround cycle between owners.
module bus_grant_sequencer
  import bus_pkg::*;
#(
  parameter int NUMUNITS     = DEF_NUMUNITS,
  parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_roundORpriority,
  input  logic [NUMUNITS-1:0]              i_request,
  input  logic [ADDRESSWIDTH*NUMUNITS-1:0] i_priority,
  input  logic                             i_beat,
  input  logic                             i_last,
  output logic [NUMUNITS-1:0]              o_grant,
  output logic [ADDRESSWIDTH-1:0]          o_owner,
  output logic                             o_busy,
  output logic                             o_timeout_err
);

  localparam int                      WDW      = wd_width(TIMEOUT);
  localparam logic [WDW-1:0]          WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [ADDRESSWIDTH-1:0] PTR_LAST = ADDRESSWIDTH'(NUMUNITS - 1);

  state_t                  r_state,  w_next_state;
  logic [NUMUNITS-1:0]     r_grant,  w_next_grant;
  logic [ADDRESSWIDTH-1:0] r_owner,  w_next_owner;
  logic                    r_busy,   w_next_busy;
  logic                    r_terr,   w_next_terr;
  logic [ADDRESSWIDTH-1:0] r_ptr,    w_next_ptr;
  logic [WDW-1:0]          r_wd,     w_next_wd;

  logic                    w_sel_valid;
  logic [ADDRESSWIDTH-1:0] w_sel_winner;
  logic [NUMUNITS-1:0]     w_sel_onehot;
  logic [ADDRESSWIDTH-1:0] w_ptr_after;
  logic                    w_owner_req;
  logic                    w_final_beat;
  logic                    w_wd_expired;

  grant_select #(
    .NUMUNITS     (NUMUNITS),
    .ADDRESSWIDTH (ADDRESSWIDTH)
  ) u_grant_select (
    .i_request         (i_request),
    .i_priority        (i_priority),
    .i_roundORpriority (i_roundORpriority),
    .i_pointer         (r_ptr),
    .o_valid           (w_sel_valid),
    .o_winner          (w_sel_winner)
  );

  assign w_owner_req  = i_request[r_owner];
  assign w_final_beat = i_beat && i_last;
  assign w_wd_expired = !i_beat && (r_wd == WD_LAST);

  // Decode the winner to one-hot and compute the pointer slot just after it.
  always_comb begin
    w_sel_onehot               = '0;
    w_sel_onehot[w_sel_winner] = 1'b1;
    if (w_sel_winner == PTR_LAST) begin
      w_ptr_after = '0;
    end else begin
      w_ptr_after = w_sel_winner + ADDRESSWIDTH'(1);
    end
  end

  // Next-state and next-output logic; everything holds unless a branch says otherwise.
  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_grant;
    w_next_owner = r_owner;
    w_next_busy  = r_busy;
    w_next_terr  = 1'b0;
    w_next_ptr   = r_ptr;
    w_next_wd    = r_wd;
    case (r_state)
      IDLE, RELEASE: begin
        // Arbitrate; beat/last are meaningless without an owner.
        if (w_sel_valid) begin
          w_next_state = OWNED;
          w_next_grant = w_sel_onehot;
          w_next_owner = w_sel_winner;
          w_next_busy  = 1'b1;
          w_next_ptr   = w_ptr_after;
          w_next_wd    = '0;
        end else begin
          w_next_state = IDLE;
          w_next_grant = '0;
          w_next_busy  = 1'b0;
        end
      end
      OWNED: begin
        // Release causes in precedence order: last beat, abandon, watchdog.
        if (w_final_beat) begin
          w_next_state = RELEASE;
          w_next_grant = '0;
          w_next_busy  = 1'b0;
        end else if (!w_owner_req) begin
          w_next_state = RELEASE;
          w_next_grant = '0;
          w_next_busy  = 1'b0;
        end else if (w_wd_expired) begin
          w_next_state = RELEASE;
          w_next_grant = '0;
          w_next_busy  = 1'b0;
          w_next_terr  = 1'b1;
        end else if (i_beat) begin
          w_next_wd    = '0;
        end else begin
          w_next_wd    = r_wd + WDW'(1);
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_grant = '0;
        w_next_busy  = 1'b0;
      end
    endcase
  end

  // State register and registered outputs; reset clears everything at once.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_busy  <= 1'b0;
      r_terr  <= 1'b0;
      r_ptr   <= '0;
      r_wd    <= '0;
    end else begin
      r_state <= w_next_state;
      r_grant <= w_next_grant;
      r_owner <= w_next_owner;
      r_busy  <= w_next_busy;
      r_terr  <= w_next_terr;
      r_ptr   <= w_next_ptr;
      r_wd    <= w_next_wd;
    end
  end

  assign o_grant       = r_grant;
  assign o_owner       = r_owner;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_terr;

endmodule

// File: tb/tb_bus_grant_sequencer.sv
// Self-checking bench for bus_grant_sequencer: a round-robin vector table,
// directed multi-cycle sequences, and randomized traffic against a model.
module tb_bus_grant_sequencer;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rop = 1'b0;
  logic [N-1:0]  req = '0;
  logic [AW*N-1:0] prio = '0;
  logic          beat = 1'b0;
  logic          last = 1'b0;
  logic [N-1:0]  grant;
  logic [AW-1:0] owner;
  logic          busy;
  logic          terr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: 0 idle, 1 owned, 2 release.
  int       m_state, m_owner, m_ptr, m_quiet;
  logic [N-1:0]  e_grant;
  logic [AW-1:0] e_owner;
  logic     e_busy, e_terr;

  typedef struct {
    logic          rop;
    logic [N-1:0]  req;
    logic          beat;
    logic          last;
    logic [N-1:0]  exp_grant;
    logic          exp_busy;
    logic [AW-1:0] exp_owner;
  } vec_t;
  vec_t vecs[$];

  bus_grant_sequencer #(.NUMUNITS(N), .ADDRESSWIDTH(AW), .TIMEOUT(TO)) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_roundORpriority (rop),
    .i_request         (req),
    .i_priority        (prio),
    .i_beat            (beat),
    .i_last            (last),
    .o_grant           (grant),
    .o_owner           (owner),
    .o_busy            (busy),
    .o_timeout_err     (terr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation exceeded its time budget");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner = requester with the smallest (priority, distance from pointer) key.
  function automatic int pick(input logic [N-1:0] r, input logic [AW*N-1:0] p,
                              input logic mode, input int ptr);
    int best, best_key, key;
    best = -1;
    best_key = 1 << 30;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        key = (mode ? int'(p[i*AW +: AW]) * N : 0) + ((i - ptr + N) % N);
        if (key < best_key) begin
          best_key = key;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_state = 0; m_owner = 0; m_ptr = 0; m_quiet = 0;
    e_grant = '0; e_owner = '0; e_busy = 1'b0; e_terr = 1'b0;
  endtask

  task automatic model_step();
    int w;
    e_terr = 1'b0;
    if (m_state == 1) begin
      if (beat && last) m_state = 2;
      else if (!req[m_owner]) m_state = 2;
      else if (!beat) begin
        m_quiet++;
        if (m_quiet == TO) begin
          m_state = 2;
          e_terr = 1'b1;
        end
      end else m_quiet = 0;
    end else begin
      w = pick(req, prio, rop, m_ptr);
      if (w >= 0) begin
        m_state = 1; m_owner = w; m_ptr = (w + 1) % N; m_quiet = 0;
      end else m_state = 0;
    end
    e_busy  = (m_state == 1);
    e_grant = e_busy ? N'(32'd1 << m_owner) : '0;
    e_owner = AW'(m_owner);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model();
    chk("grant", 32'(grant), 32'(e_grant));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("timeout_err", 32'(terr), 32'(e_terr));
    if (e_busy) chk("owner", 32'(owner), 32'(e_owner));
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_owner", 32'(owner), 32'd0);
    chk("reset_terr", 32'(terr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    beat = 1'b0; last = 1'b0; req = '0;
  endtask

  task automatic set_prio_all(input int v);
    for (int i = 0; i < N; i++) prio[i*AW +: AW] = AW'(v);
  endtask

  initial begin
    vec_t v;
    // Round-robin table: request all, 2-beat bursts, owners 0..7 then 0 again.
    for (int u = 0; u <= N; u++) begin
      int o;
      o = u % N;
      v.rop = 1'b0; v.req = 8'hFF; v.exp_owner = AW'(o);
      v.beat = 1'b0; v.last = 1'b0; v.exp_grant = N'(32'd1 << o); v.exp_busy = 1'b1;
      vecs.push_back(v);
      v.beat = 1'b1; v.last = 1'b0;
      vecs.push_back(v);
      v.beat = 1'b1; v.last = 1'b1; v.exp_grant = '0; v.exp_busy = 1'b0;
      vecs.push_back(v);
    end

    do_reset();
    set_prio_all(0);
    for (int i = 0; i < vecs.size(); i++) begin
      rop = vecs[i].rop; req = vecs[i].req; beat = vecs[i].beat; last = vecs[i].last;
      tick();
      chk("rr_grant", 32'(grant), 32'(vecs[i].exp_grant));
      chk("rr_busy", 32'(busy), 32'(vecs[i].exp_busy));
      if (vecs[i].exp_busy) chk("rr_owner", 32'(owner), 32'(vecs[i].exp_owner));
    end

    // Priority: unit i has priority 7-i, request 0F -> unit 3.
    do_reset();
    for (int i = 0; i < N; i++) prio[i*AW +: AW] = AW'(7 - i);
    rop = 1'b1; req = 8'h0F;
    tick();
    chk("prio_grant", 32'(grant), 32'h08);
    chk("prio_owner", 32'(owner), 32'd3);

    // Tie between units 1 and 3 with pointer at 2: unit 3 first, then unit 1.
    do_reset();
    rop = 1'b0; req = 8'h02;
    tick();
    chk("tie_setup", 32'(grant), 32'h02);
    set_prio_all(5);
    prio[1*AW +: AW] = 3'd2; prio[3*AW +: AW] = 3'd2;
    rop = 1'b1; req = 8'h0A; beat = 1'b1; last = 1'b1;
    tick();
    chk("tie_release", 32'(grant), 32'h00);
    beat = 1'b0; last = 1'b0;
    tick();
    chk("tie_first", 32'(grant), 32'h08);
    beat = 1'b1; last = 1'b1;
    tick();
    chk("tie_gap", 32'(grant), 32'h00);
    beat = 1'b0; last = 1'b0;
    tick();
    chk("tie_second", 32'(grant), 32'h02);

    // Hold: owner 4 keeps the bus while more urgent unit 0 waits.
    do_reset();
    set_prio_all(5);
    prio[0 +: AW] = 3'd0;
    rop = 1'b1; req = 8'h10;
    tick();
    chk("hold_grant", 32'(grant), 32'h10);
    req = 8'h11; beat = 1'b1;
    tick();
    chk("hold_beat", 32'(grant), 32'h10);
    beat = 1'b0;
    tick();
    chk("hold_idle_beat", 32'(grant), 32'h10);
    beat = 1'b1; last = 1'b1;
    tick();
    chk("hold_release", 32'(grant), 32'h00);
    chk("hold_release_busy", 32'(busy), 32'd0);
    beat = 1'b0; last = 1'b0;
    tick();
    chk("hold_next", 32'(grant), 32'h01);

    // Watchdog: 15 beat-less owned cycles, then one-cycle timeout_err.
    do_reset();
    rop = 1'b0; req = 8'h01;
    tick();
    chk("wd_grant", 32'(grant), 32'h01);
    for (int k = 1; k < TO; k++) begin
      tick();
      chk("wd_hold", 32'(grant), 32'h01);
      chk("wd_no_err", 32'(terr), 32'd0);
    end
    tick();
    chk("wd_expire_grant", 32'(grant), 32'h00);
    chk("wd_expire_err", 32'(terr), 32'd1);
    req = 8'h00;
    tick();
    chk("wd_err_pulse", 32'(terr), 32'd0);
    req = 8'h01;
    tick();
    chk("wd_regrant", 32'(grant), 32'h01);
    for (int k = 1; k < 10 + TO; k++) begin
      beat = (k == 10);
      tick();
      chk("wd_restart_hold", 32'(grant), 32'h01);
    end
    beat = 1'b0;
    tick();
    chk("wd_restart_expire", 32'(grant), 32'h00);
    chk("wd_restart_err", 32'(terr), 32'd1);

    // Abandon, then beat/last while idle.
    do_reset();
    req = 8'h04;
    tick();
    chk("ab_grant", 32'(grant), 32'h04);
    req = 8'h00; beat = 1'b1;
    tick();
    chk("ab_release", 32'(grant), 32'h00);
    chk("ab_no_err", 32'(terr), 32'd0);
    last = 1'b1;
    tick();
    chk("ab_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("ab_idle_grant", 32'(grant), 32'h00);
    beat = 1'b0; last = 1'b0; req = 8'h02;
    tick();
    chk("ab_latency", 32'(grant), 32'h02);

    // Async reset mid-burst: outputs drop without a clock edge; pointer back to 0.
    do_reset();
    req = 8'h20;
    tick();
    chk("ar_grant", 32'(grant), 32'h20);
    beat = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("ar_grant_drop", 32'(grant), 32'h00);
    chk("ar_busy_drop", 32'(busy), 32'd0);
    chk("ar_no_err", 32'(terr), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0; beat = 1'b0; req = 8'h81;
    tick();
    chk("ar_ptr_zero", 32'(grant), 32'h01);

    // Randomized traffic against the reference model.
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      int beat_pct, chg_pct;
      beat_pct = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 35 : 85);
      chg_pct  = (seg % 3 == 0) ? 2 : 12;
      for (int c = 0; c < 500; c++) begin
        if (int'($urandom_range(0, 99)) < chg_pct) req = N'($urandom());
        if ($urandom_range(0, 9) == 0) prio = (AW*N)'($urandom());
        rop  = 1'($urandom_range(0, 1));
        beat = (int'($urandom_range(0, 99)) < beat_pct);
        last = ($urandom_range(0, 3) == 0);
        tick();
        check_model();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
